uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Runtime-configurable UART receiver. It is the successor to the fixed 8N1 receiver, driven by the same shared oversampling baud tick `s_tick`.
- Adds: 5..DBIT_MAX data bits; none/even/odd parity; 1 or 2 stop bits; 3-sample majority voting; false-start rejection; framing, parity and break detection.
- Output: valid/ready holding register with overrun reporting.
- Placement: between the baud generator and the RX FIFO / register interface.

Parameters:
DBIT_MAX, 9, widest supported data field; `dout` width; legal range 5..9
OVS, 16, s_tick pulses per bit; even, >=8
SYNC_STAGES, 2, flip-flop depth of the rx input synchroniser; >=2

Ports:
clk  in  1  system clock
reset_n  in  1  reset
s_tick  in  1  oversample enable, one clk wide, OVS per bit period
rx  in  1  asynchronous serial input, idle high
cfg_dbits  in  4  data bits per frame; <5 treated as 5, >DBIT_MAX treated as DBIT_MAX
cfg_parity  in  2  0=none, 1=even, 2=odd, 3=none
cfg_stop2  in  1  0=one stop bit, 1=two stop bits
dout  out  DBIT_MAX  received data, LSB-aligned, unused upper bits 0
dout_valid  out  1  `dout` and the error flags are valid
dout_ready  in  1  consumer accepts when valid&&ready
par_err  out  1  parity mismatch, qualified by dout_valid
frm_err  out  1  a stop bit sampled 0, qualified by dout_valid
brk  out  1  break frame, qualified by dout_valid
ovr_tick  out  1  one-clk pulse: completed frame dropped because the holding register was full
busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset: reset_n is synchronous, active-low; clock clk.
  - State goes to IDLE; all counters, `dout`, and all flag outputs are 0.
  - Synchroniser flops reset to 1.
  - Reset mid-frame abandons the frame with no output.
- Synchronising and sampling:
  - All logic uses `rxs`, the rx signal after SYNC_STAGES flops.
  - Tick counter s counts 0..OVS-1 on s_tick.
  - Bit value = majority of rxs at s = OVS/2-1, OVS/2, OVS/2+1.
- Config capture: cfg_* is latched on the IDLE->START transition. Changes mid-frame have no effect.
- FSM states and transitions:
  - IDLE: rxs==0 -> START with s=0. The s_tick gate is not required for this transition.
  - START:
    - At s==OVS/2+1, evaluate the majority. If it is 1, this is a false start: return to IDLE with no output.
    - At s==OVS-1 -> DATA with n=0, s=0.
  - DATA: at s==OVS-1, shift the voted bit in LSB-first; s=0. When n==dbits-1 -> PARITY if parity is enabled, else STOP. Otherwise n++.
  - PARITY: at s==OVS-1, store the voted bit -> STOP.
    - par_err = (XOR of data bits ^ parity bit) != 0 for even parity.
    - For odd parity, par_err = that XOR == 0.
  - STOP: the voted value of each stop bit is ANDed into a stop_ok accumulator.
    - First stop bit with stop2=1: at s==OVS-1, continue to the second stop bit.
    - Final stop bit: at s==OVS/2+1, complete the frame (mid-bit exit, resynchronises to a following start).
    - On completion, frm_err = !stop_ok; brk = (data==0 && parity bit 0-or-absent && !stop_ok).
    - Next state: if brk -> BRKWAIT, else IDLE.
  - BRKWAIT: remain until rxs==1, then -> IDLE. A low line must not retrigger START.
- Output handshake:
  - Frame completion with dout_valid==0 loads `dout` and the flags and sets dout_valid on the next clk.
  - Completion with dout_valid==1 && !dout_ready: the frame is dropped, ovr_tick pulses, and the held data is unchanged.
  - Completion in the same cycle as valid&&ready: load the new frame; dout_valid stays 1; no overrun.
  - valid&&ready with no completion: dout_valid is cleared next clk.
- Latency: dout_valid rises 1 clk after the completion tick.
- Widths:
  - s counter: clog2(OVS) bits.
  - n counter: clog2(DBIT_MAX) bits.
  - Shift register: DBIT_MAX bits; bits shift in at position dbits-1, so the result is LSB-aligned with zero upper bits.

Decomposition:
- Package uart_pkg:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
  - Parity mode constants: PAR_NONE, PAR_EVEN, PAR_ODD.
  - MIN_DBITS = 5.
- Sub-module uart_rx_sampler: synchroniser plus 3-sample majority voter. Inputs: `rx`, `s_tick`, s counter. Outputs: `rxs` and the voted bit.

Test Plan:
Settings for all scenarios: OVS=16, s_tick every clk, dout_ready=1 unless stated.
- 8N1, byte 0xA5 -> dout=0x0A5, dout_valid one clk after the first stop mid-bit, par_err=frm_err=brk=0.
- 7E2, data 0x35 with parity bit 0 -> dout=0x35, par_err=0; repeat with parity bit 1 -> par_err=1; second stop bit driven 0 -> frm_err=1.
- Glitches:
  - 5-tick low pulse on the idle line -> false start, returns to IDLE, no dout_valid.
  - One-tick glitch at the mid-sample of data bit 3 of 0x00 -> majority vote yields dout=0x00.
- 9N1, 0x1FF, then rx held low for 2 frame times -> first dout=0x1FF; second frame dout=0, frm_err=1, brk=1. busy stays high until rx returns high, and no extra frames are produced.
- dout_ready=0: send 0x11 then 0x22 -> dout holds 0x11, ovr_tick pulses once at completion of 0x22. Raise ready in the completion cycle of a third frame 0x33 -> dout=0x33, no ovr_tick.
- Change cfg_dbits from 8 to 5 mid-frame -> the current frame is still received as 8 bits; the next frame is received as 5 bits. Assert reset_n low mid-DATA -> IDLE and no output.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Holds the FSM state enum, parity mode codes and the data-width clamp.
// No logic of its own; imported by the receiver files.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRKWAIT
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int MIN_DBITS = 5;

  // Requested data width forced into MIN_DBITS..dmax.
  function automatic logic [3:0] clamp_dbits(input logic [3:0] req, input int dmax);
    if (int'(req) < MIN_DBITS) return 4'(MIN_DBITS);
    if (int'(req) > dmax) return 4'(dmax);
    return req;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Received-frame bus: data, status flags and the valid/ready handshake.
// The master side owns data/flags/valid; the slave side owns ready.
// Data and flags are only meaningful while dout_valid is high.
interface uart_rx_cfg_if #(
  parameter int DBIT_MAX = 9
);
  logic [DBIT_MAX-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;
  logic                par_err;
  logic                frm_err;
  logic                brk;

  modport master (output dout, dout_valid, par_err, frm_err, brk, input dout_ready);
  modport slave  (input dout, dout_valid, par_err, frm_err, brk, output dout_ready);
endinterface

// File: rtl/uart_rx_sampler.sv
// rx synchroniser plus 3-sample majority voter around the bit centre.
// rxs lags rx by SYNC_STAGES clk; vote is combinational at s==OVS/2+1.
// No backpressure: samples whenever s_tick fires at the chosen s values.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SW          = $clog2(OVS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx,
  input  logic          s_tick,
  input  logic [SW-1:0] s,
  output logic          rxs,
  output logic          vote,
  output logic          vote_q
);
  localparam logic [SW-1:0] S_A = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_B = SW'(OVS/2);
  localparam logic [SW-1:0] S_C = SW'(OVS/2 + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   smp_a;
  logic                   smp_b;

  // Metastability chain; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Majority of the two stored samples and the live third sample.
  assign vote = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);

  // Capture the first two centre samples and hold the finished vote for the bit end.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      smp_a  <= 1'b0;
      smp_b  <= 1'b0;
      vote_q <= 1'b0;
    end else if (s_tick) begin
      if (s == S_A) smp_a  <= rxs;
      if (s == S_B) smp_b  <= rxs;
      if (s == S_C) vote_q <= vote;
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..DBIT_MAX data, none/even/odd parity, 1/2 stop.
// dout_valid rises 1 clk after the final stop bit's mid-sample tick.
// Holding register: a frame completing while valid && !ready is dropped and flagged by ovr_tick.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT_MAX    = 9,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic                 rx,
  input  logic [3:0]           cfg_dbits,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  uart_rx_cfg_if.master        frame,
  output logic                 ovr_tick,
  output logic                 busy
);
  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(DBIT_MAX);
  localparam logic [SW-1:0] S_MID = SW'(OVS/2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVS - 1);

  rx_state_t           state, state_nxt;
  logic [SW-1:0]       s;
  logic [NW-1:0]       n;
  logic [DBIT_MAX-1:0] shreg, shift_in;
  logic [3:0]          dbits_q;
  logic [1:0]          par_q;
  logic                stop2_q, par_bit, stop_ok, stop_idx;
  logic                rxs, vote, vote_q;
  logic                tick_mid, tick_end, par_en, last_data, last_stop;
  logic                stop_ok_fin, done, par_err_now, brk_now;

  uart_rx_sampler #(.OVS(OVS), .SYNC_STAGES(SYNC_STAGES), .SW(SW)) u_sampler (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .s_tick  (s_tick),
    .s       (s),
    .rxs     (rxs),
    .vote    (vote),
    .vote_q  (vote_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a low line in BRKWAIT never restarts a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rxs) state_nxt = START;
      START:   if (tick_mid && vote) state_nxt = IDLE;
               else if (tick_end)    state_nxt = DATA;
      DATA:    if (tick_end && last_data) state_nxt = par_en ? PARITY : STOP;
      PARITY:  if (tick_end) state_nxt = STOP;
      STOP:    if (done) state_nxt = brk_now ? BRKWAIT : IDLE;
      BRKWAIT: if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes and frame verdicts decoded from state and counters.
  always_comb begin
    tick_mid    = s_tick && (s == S_MID);
    tick_end    = s_tick && (s == S_END);
    par_en      = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    last_data   = (int'(n) == int'(dbits_q) - 1);
    last_stop   = !stop2_q || stop_idx;
    stop_ok_fin = stop_ok & vote;
    done        = (state == STOP) && last_stop && tick_mid;
    par_err_now = par_en && (^shreg ^ par_bit ^ (par_q == PAR_ODD));
    brk_now     = (shreg == '0) && !(par_en && par_bit) && !stop_ok_fin;
    busy        = (state != IDLE);
  end

  // Shift LSB-first, entering at the top of the configured field so the result is LSB-aligned.
  always_comb begin
    shift_in = shreg >> 1;
    shift_in[dbits_q - 4'd1] = vote_q;
  end

  // Counters, config snapshot and frame datapath.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s        <= '0;
      n        <= '0;
      shreg    <= '0;
      dbits_q  <= 4'(MIN_DBITS);
      par_q    <= PAR_NONE;
      stop2_q  <= 1'b0;
      par_bit  <= 1'b0;
      stop_ok  <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      if (state == IDLE) begin
        s <= '0;
        if (!rxs) begin
          n        <= '0;
          shreg    <= '0;
          dbits_q  <= clamp_dbits(cfg_dbits, DBIT_MAX);
          par_q    <= cfg_parity;
          stop2_q  <= cfg_stop2;
          par_bit  <= 1'b0;
          stop_ok  <= 1'b1;
          stop_idx <= 1'b0;
        end
      end else if (state == BRKWAIT) begin
        s <= '0;
      end else if (s_tick) begin
        s <= tick_end ? '0 : s + 1'b1;
      end
      if (state == DATA && tick_end) begin
        shreg <= shift_in;
        if (!last_data) n <= n + 1'b1;
      end
      if (state == PARITY && tick_end) par_bit <= vote_q;
      if (state == STOP && tick_mid)   stop_ok <= stop_ok & vote;
      if (state == STOP && tick_end)   stop_idx <= 1'b1;
    end
  end

  // Holding register with overrun detection; a same-cycle pop makes room for the new frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame.dout       <= '0;
      frame.dout_valid <= 1'b0;
      frame.par_err    <= 1'b0;
      frame.frm_err    <= 1'b0;
      frame.brk        <= 1'b0;
      ovr_tick         <= 1'b0;
    end else begin
      ovr_tick <= 1'b0;
      if (done && (!frame.dout_valid || frame.dout_ready)) begin
        frame.dout       <= shreg;
        frame.par_err    <= par_err_now;
        frame.frm_err    <= !stop_ok_fin;
        frame.brk        <= brk_now;
        frame.dout_valid <= 1'b1;
      end else begin
        if (done) ovr_tick <= 1'b1;
        if (frame.dout_valid && frame.dout_ready) frame.dout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: OVS=16, s_tick every clk, rx driven per bit at negedges.
// Outputs are observed at negedges; a transfer is valid&&ready seen at a negedge.
// Expected values are hand-derived frame contents and completion cycle offsets.
module tb_uart_rx_cfg;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tick;
  logic       rx;
  logic [3:0] cfg_dbits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       ovr_tick;
  logic       busy;

  uart_rx_cfg_if #(.DBIT_MAX(9)) bus ();

  uart_rx_cfg #(.DBIT_MAX(9), .OVS(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_tick     (s_tick),
    .rx         (rx),
    .cfg_dbits  (cfg_dbits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .frame      (bus),
    .ovr_tick   (ovr_tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc, first_vc, nxfer, novr;
  logic [8:0] cap_dout;
  logic       cap_par, cap_frm, cap_brk, saw_busy;
  logic [15:0] v;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    cyc = 0; first_vc = -1; nxfer = 0; novr = 0; saw_busy = 1'b0;
    cap_dout = '0; cap_par = 1'b0; cap_frm = 1'b0; cap_brk = 1'b0;
  endtask

  // Hold rx at b for n clocks, recording transfers, overrun pulses and busy.
  task automatic drive(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      rx = b;
      @(negedge clk);
      if (bus.dout_valid && bus.dout_ready) begin
        nxfer++;
        cap_dout = bus.dout;
        cap_par  = bus.par_err;
        cap_frm  = bus.frm_err;
        cap_brk  = bus.brk;
        if (first_vc < 0) first_vc = cyc;
      end
      if (ovr_tick) novr++;
      if (busy) saw_busy = 1'b1;
      cyc++;
    end
  endtask

  // Frame bit vector, bit 0 = start; stop1 is always 1, stop2 value given.
  function automatic logic [15:0] fbits(input logic [8:0] d, input int nd, input int hp,
                                        input logic pb, input logic s2);
    logic [15:0] r;
    r = '1;
    r[0] = 1'b0;
    for (int i = 0; i < nd; i++) r[1+i] = d[i];
    if (hp != 0) r[1+nd] = pb;
    r[2+nd+hp] = s2;
    return r;
  endfunction

  task automatic send(input logic [15:0] bits, input int nb);
    for (int b = 0; b < nb; b++) drive(bits[b], 16);
  endtask

  initial begin
    reset_n = 1'b0; s_tick = 1'b1; rx = 1'b1;
    cfg_dbits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    bus.dout_ready = 1'b1;
    mon_clear();
    repeat (3) @(negedge clk);
    check("rst_dout", 16'(bus.dout), 16'h0);
    check("rst_valid", 16'(bus.dout_valid), 16'h0);
    check("rst_flags", 16'({bus.par_err, bus.frm_err, bus.brk}), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_ovr", 16'(ovr_tick), 16'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 8N1 0xA5
    mon_clear();
    send(fbits(9'h0A5, 8, 0, 1'b0, 1'b1), 10);
    drive(1'b1, 16);
    check("8n1_xfer", 16'(nxfer), 16'd1);
    check("8n1_latency", 16'(first_vc), 16'd156);
    check("8n1_dout", 16'(cap_dout), 16'h0A5);
    check("8n1_flags", 16'({cap_par, cap_frm, cap_brk}), 16'h0);
    check("8n1_busy_end", 16'(busy), 16'h0);

    // 7E2 0x35: good parity, bad parity, bad second stop
    cfg_dbits = 4'd7; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
    mon_clear();
    send(fbits(9'h035, 7, 1, 1'b0, 1'b1), 11);
    drive(1'b1, 32);
    check("7e2_latency", 16'(first_vc), 16'd172);
    check("7e2_dout", 16'(cap_dout), 16'h035);
    check("7e2_par_ok", 16'(cap_par), 16'h0);
    check("7e2_frm_ok", 16'(cap_frm), 16'h0);
    mon_clear();
    send(fbits(9'h035, 7, 1, 1'b1, 1'b1), 11);
    drive(1'b1, 32);
    check("7e2_par_bad", 16'(cap_par), 16'h1);
    check("7e2_par_bad_dout", 16'(cap_dout), 16'h035);
    mon_clear();
    send(fbits(9'h035, 7, 1, 1'b0, 1'b0), 11);
    drive(1'b1, 48);
    check("7e2_stop2_xfer", 16'(nxfer), 16'd1);
    check("7e2_stop2_frm", 16'(cap_frm), 16'h1);
    check("7e2_stop2_par_brk", 16'({cap_par, cap_brk}), 16'h0);

    // 5-tick low glitch on idle line is a false start
    cfg_dbits = 4'd8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    mon_clear();
    drive(1'b0, 5);
    drive(1'b1, 40);
    check("glitch_start_xfer", 16'(nxfer), 16'd0);
    check("glitch_start_sawbusy", 16'(saw_busy), 16'h1);
    check("glitch_start_idle", 16'(busy), 16'h0);

    // 0x00 with a one-tick high glitch at the centre of data bit 3
    mon_clear();
    drive(1'b0, 73);
    drive(1'b1, 1);
    drive(1'b0, 70);
    drive(1'b1, 32);
    check("glitch_data_xfer", 16'(nxfer), 16'd1);
    check("glitch_data_dout", 16'(cap_dout), 16'h000);
    check("glitch_data_flags", 16'({cap_par, cap_frm, cap_brk}), 16'h0);

    // 9N1 0x1FF then line held low two frame times -> break
    cfg_dbits = 4'd9;
    mon_clear();
    send(fbits(9'h1FF, 9, 0, 1'b0, 1'b1), 11);
    check("9n1_dout", 16'(cap_dout), 16'h1FF);
    check("9n1_xfer", 16'(nxfer), 16'd1);
    mon_clear();
    drive(1'b0, 352);
    check("brk_xfer", 16'(nxfer), 16'd1);
    check("brk_latency", 16'(first_vc), 16'd172);
    check("brk_dout", 16'(cap_dout), 16'h000);
    check("brk_flags", 16'({cap_par, cap_frm, cap_brk}), 16'h3);
    check("brk_busy_low", 16'(busy), 16'h1);
    mon_clear();
    drive(1'b1, 32);
    check("brk_busy_release", 16'(busy), 16'h0);
    check("brk_no_extra", 16'(nxfer), 16'd0);

    // Backpressure: overrun on 0x22, pop-and-load on 0x33
    cfg_dbits = 4'd8;
    bus.dout_ready = 1'b0;
    mon_clear();
    send(fbits(9'h011, 8, 0, 1'b0, 1'b1), 10);
    drive(1'b1, 16);
    check("hold_valid", 16'(bus.dout_valid), 16'h1);
    check("hold_dout", 16'(bus.dout), 16'h011);
    check("hold_no_ovr", 16'(novr), 16'd0);
    mon_clear();
    send(fbits(9'h022, 8, 0, 1'b0, 1'b1), 10);
    drive(1'b1, 16);
    check("ovr_count", 16'(novr), 16'd1);
    check("ovr_dout_kept", 16'(bus.dout), 16'h011);
    check("ovr_valid_kept", 16'(bus.dout_valid), 16'h1);
    mon_clear();
    v = fbits(9'h033, 8, 0, 1'b0, 1'b1);
    for (int b = 0; b < 9; b++) drive(v[b], 16);
    drive(1'b1, 12);
    bus.dout_ready = 1'b1;
    drive(1'b1, 20);
    check("popload_latency", 16'(first_vc), 16'd156);
    check("popload_dout", 16'(cap_dout), 16'h033);
    check("popload_xfer", 16'(nxfer), 16'd1);
    check("popload_no_ovr", 16'(novr), 16'd0);
    check("popload_valid_clr", 16'(bus.dout_valid), 16'h0);

    // cfg_dbits change mid-frame takes effect on the next frame only
    mon_clear();
    v = fbits(9'h05A, 8, 0, 1'b0, 1'b1);
    for (int b = 0; b < 4; b++) drive(v[b], 16);
    cfg_dbits = 4'd5;
    for (int b = 4; b < 10; b++) drive(v[b], 16);
    drive(1'b1, 16);
    check("cfgchg_dout", 16'(cap_dout), 16'h05A);
    check("cfgchg_latency", 16'(first_vc), 16'd156);
    mon_clear();
    send(fbits(9'h015, 5, 0, 1'b0, 1'b1), 7);
    drive(1'b1, 16);
    check("5n1_dout", 16'(cap_dout), 16'h015);
    check("5n1_latency", 16'(first_vc), 16'd108);

    // Reset in the middle of DATA abandons the frame
    cfg_dbits = 4'd8;
    mon_clear();
    v = fbits(9'h077, 8, 0, 1'b0, 1'b1);
    for (int b = 0; b < 3; b++) drive(v[b], 16);
    check("midrst_busy_before", 16'(busy), 16'h1);
    reset_n = 1'b0;
    drive(1'b1, 3);
    reset_n = 1'b1;
    drive(1'b1, 1);
    check("midrst_busy", 16'(busy), 16'h0);
    check("midrst_dout", 16'(bus.dout), 16'h000);
    check("midrst_valid", 16'(bus.dout_valid), 16'h0);
    drive(1'b1, 200);
    check("midrst_no_output", 16'(nxfer), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
